// File: rtl/mult_table_pkg.sv
// Shared types and helpers for the multiplication-table scanner.
package mult_table_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width that never collapses to zero bits for a single-entry dimension.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_table_rom.sv
// Constant i*j product table built in nested generate scopes, looked up by (row, col).
module mult_table_rom
  import mult_table_pkg::*;
#(
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int ROW_W  = clog2_min1(ROWS),
  parameter int COL_W  = clog2_min1(COLS),
  parameter int PROD_W = ROW_W + COL_W
) (
  input  logic [ROW_W-1:0]  row_i,
  input  logic [COL_W-1:0]  col_i,
  output logic [PROD_W-1:0] prod_o
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = clog2_min1(CELLS);

  logic [CELLS*PROD_W-1:0] table_flat;
  logic [PROD_W-1:0]       cells [CELLS];
  logic [IDX_W-1:0]        idx;

  for (genvar i = 0; i < ROWS; i++) begin : FOR_ROW
    for (genvar j = 0; j < COLS; j++) begin : FOR_COL
      localparam logic [PROD_W-1:0] CELL = PROD_W'(i * j);
      assign table_flat[(i*COLS+j)*PROD_W +: PROD_W] = CELL;
    end
  end

  for (genvar k = 0; k < CELLS; k++) begin : FOR_CELL
    assign cells[k] = table_flat[k*PROD_W +: PROD_W];
  end

  assign idx    = IDX_W'(row_i) * IDX_W'(COLS) + IDX_W'(col_i);
  assign prod_o = cells[idx];

endmodule

// File: rtl/mult_table_scanner.sv
// Walks the product table row- or column-major and streams (i, j, i*j) over valid/ready.
module mult_table_scanner
  import mult_table_pkg::*;
#(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int SKIP_ZERO = 0,
  parameter int ROW_W     = clog2_min1(ROWS),
  parameter int COL_W     = clog2_min1(COLS),
  parameter int PROD_W    = ROW_W + COL_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              col_major,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic [PROD_W-1:0] out_prod,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ROW_W-1:0] ROW_START = (SKIP_ZERO != 0) ? ROW_W'(1) : '0;
  localparam logic [COL_W-1:0] COL_START = (SKIP_ZERO != 0) ? COL_W'(1) : '0;
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  // With zero indices skipped, a single-row or single-column table has nothing to emit.
  localparam bit EMPTY = (SKIP_ZERO != 0) && (ROWS == 1 || COLS == 1);

  state_e            state_q, state_d;
  logic              col_major_q, col_major_d;
  logic              valid_q, valid_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              last_q, last_d;

  mult_table_rom #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .PROD_W (PROD_W)
  ) u_rom (
    .row_i  (row_d),
    .col_i  (col_d),
    .prod_o (prod_d)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    col_major_d = col_major_q;
    valid_d     = valid_q;
    row_d       = row_q;
    col_d       = col_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          col_major_d = col_major;
          if (EMPTY) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
            valid_d = 1'b1;
            row_d   = ROW_START;
            col_d   = COL_START;
          end
        end
      end
      SCAN: begin
        if (valid_q && out_ready) begin
          if (last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else if (!col_major_q) begin
            if (col_q == COL_LAST) begin
              col_d = COL_START;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            if (row_q == ROW_LAST) begin
              row_d = ROW_START;
              col_d = col_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    last_d = valid_d && (row_d == ROW_LAST) && (col_d == COL_LAST);
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      col_major_q <= 1'b0;
      valid_q     <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      prod_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_major_q <= col_major_d;
      valid_q     <= valid_d;
      row_q       <= row_d;
      col_q       <= col_d;
      prod_q      <= prod_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_prod  = prod_q;
  assign out_last  = last_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mult_table_scanner.sv
// Four scanner configurations checked every cycle against a queue-based model of the scan order.
module tb_mult_table_scanner;

  localparam int N = 4;
  localparam int ROWS_P [N] = '{5, 3, 5, 1};
  localparam int COLS_P [N] = '{5, 4, 5, 5};
  localparam int SKIP_P [N] = '{0, 0, 1, 1};

  typedef struct { int r; int c; } pair_t;
  typedef struct { int r; int c; int p; bit last; } xfer_t;

  logic clock;
  logic reset;
  logic [N-1:0] st, cm, rdy;
  logic [N-1:0] v, l, b, dn;

  logic [2:0] r0, c0, r2, c2;
  logic [5:0] p0, p2;
  logic [1:0] r1, c1;
  logic [3:0] p1, p3;
  logic [0:0] r3;
  logic [2:0] c3;

  logic [7:0] o_row [N];
  logic [7:0] o_col [N];
  logic [7:0] o_prod[N];

  int checks   = 0;
  int failures = 0;

  pair_t exp_q [N][$];
  xfer_t log_q [N][$];
  bit    m_busy[N];
  bit    m_done[N];
  int    done_n[N];

  mult_table_scanner #(.ROWS(5), .COLS(5), .SKIP_ZERO(0)) u_def (
    .clock(clock), .reset(reset), .start(st[0]), .col_major(cm[0]),
    .out_valid(v[0]), .out_ready(rdy[0]), .out_row(r0), .out_col(c0),
    .out_prod(p0), .out_last(l[0]), .busy(b[0]), .done(dn[0]));

  mult_table_scanner #(.ROWS(3), .COLS(4), .SKIP_ZERO(0)) u_3x4 (
    .clock(clock), .reset(reset), .start(st[1]), .col_major(cm[1]),
    .out_valid(v[1]), .out_ready(rdy[1]), .out_row(r1), .out_col(c1),
    .out_prod(p1), .out_last(l[1]), .busy(b[1]), .done(dn[1]));

  mult_table_scanner #(.ROWS(5), .COLS(5), .SKIP_ZERO(1)) u_skip (
    .clock(clock), .reset(reset), .start(st[2]), .col_major(cm[2]),
    .out_valid(v[2]), .out_ready(rdy[2]), .out_row(r2), .out_col(c2),
    .out_prod(p2), .out_last(l[2]), .busy(b[2]), .done(dn[2]));

  mult_table_scanner #(.ROWS(1), .COLS(5), .SKIP_ZERO(1)) u_empty (
    .clock(clock), .reset(reset), .start(st[3]), .col_major(cm[3]),
    .out_valid(v[3]), .out_ready(rdy[3]), .out_row(r3), .out_col(c3),
    .out_prod(p3), .out_last(l[3]), .busy(b[3]), .done(dn[3]));

  assign o_row[0] = 8'(r0);  assign o_col[0] = 8'(c0);  assign o_prod[0] = 8'(p0);
  assign o_row[1] = 8'(r1);  assign o_col[1] = 8'(c1);  assign o_prod[1] = 8'(p1);
  assign o_row[2] = 8'(r2);  assign o_col[2] = 8'(c2);  assign o_prod[2] = 8'(p2);
  assign o_row[3] = 8'(r3);  assign o_col[3] = 8'(c3);  assign o_prod[3] = 8'(p3);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Full visiting order of one scan, straight from the index ranges.
  function automatic void build(input int k, input bit col_m);
    int lo;
    lo = (SKIP_P[k] != 0) ? 1 : 0;
    exp_q[k].delete();
    if (col_m) begin
      for (int j = lo; j < COLS_P[k]; j++)
        for (int i = lo; i < ROWS_P[k]; i++) exp_q[k].push_back('{i, j});
    end else begin
      for (int i = lo; i < ROWS_P[k]; i++)
        for (int j = lo; j < COLS_P[k]; j++) exp_q[k].push_back('{i, j});
    end
  endfunction

  initial forever begin
    @(posedge clock);
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        exp_q[k].delete();
        m_busy[k] = 1'b0;
        m_done[k] = 1'b0;
      end else if (m_done[k]) begin
        m_done[k] = 1'b0;
        m_busy[k] = 1'b0;
      end else if (!m_busy[k]) begin
        if (st[k]) begin
          build(k, cm[k]);
          m_busy[k] = 1'b1;
          m_done[k] = (exp_q[k].size() == 0);
        end
      end else if (rdy[k] && exp_q[k].size() != 0) begin
        void'(exp_q[k].pop_front());
        if (exp_q[k].size() == 0) m_done[k] = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    for (int k = 0; k < N; k++) begin
      automatic bit ev = m_busy[k] && !m_done[k] && (exp_q[k].size() != 0);
      check($sformatf("valid[%0d]", k), int'(v[k]), int'(ev));
      check($sformatf("busy[%0d]", k), int'(b[k]), int'(m_busy[k]));
      check($sformatf("done[%0d]", k), int'(dn[k]), int'(m_done[k]));
      if (ev) begin
        automatic pair_t e = exp_q[k][0];
        check($sformatf("row[%0d]", k), int'(o_row[k]), e.r);
        check($sformatf("col[%0d]", k), int'(o_col[k]), e.c);
        check($sformatf("prod[%0d]", k), int'(o_prod[k]), e.r * e.c);
        check($sformatf("last[%0d]", k), int'(l[k]),
              int'(e.r == ROWS_P[k] - 1 && e.c == COLS_P[k] - 1));
      end
      if (v[k] && rdy[k] && !reset)
        log_q[k].push_back('{int'(o_row[k]), int'(o_col[k]), int'(o_prod[k]), l[k]});
      if (dn[k]) done_n[k]++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode 0: ready always high, 1: ready one cycle in three, 2: random ready/start/col_major.
  task automatic run_scan(input int k, input bit col_m, input int mode,
                          input int start_at, input int reset_at, output int cycles);
    int done0;
    bit fired;
    bit aborted;
    done0   = done_n[k];
    fired   = 1'b0;
    aborted = 1'b0;
    log_q[k].delete();
    st[k]  = 1'b1;
    cm[k]  = col_m;
    rdy[k] = 1'b0;
    tick();
    st[k]  = 1'b0;
    cycles = 1;
    while (done_n[k] == done0 && cycles < 400 && !aborted) begin
      if (reset_at >= 0 && log_q[k].size() == reset_at) begin
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        aborted = 1'b1;
      end else begin
        case (mode)
          0:       rdy[k] = 1'b1;
          1:       rdy[k] = (cycles % 3 == 0);
          default: rdy[k] = ($urandom_range(0, 3) != 0);
        endcase
        st[k] = (mode == 2) && ($urandom_range(0, 7) == 0);
        if (mode == 2) cm[k] = 1'($urandom_range(0, 1));
        if (start_at >= 0 && !fired && log_q[k].size() == start_at) begin
          st[k] = 1'b1;
          fired = 1'b1;
        end
        tick();
        cycles++;
      end
    end
    st[k]  = 1'b0;
    rdy[k] = 1'b0;
    if (!aborted) check($sformatf("scan_finished[%0d]", k), int'(done_n[k] != done0), 1);
  endtask

  task automatic check_x(input string nm, input int k, input int idx,
                         input int r, input int c, input int p);
    if (idx < log_q[k].size()) begin
      check({nm, ".row"}, log_q[k][idx].r, r);
      check({nm, ".col"}, log_q[k][idx].c, c);
      check({nm, ".prod"}, log_q[k][idx].p, p);
    end else begin
      check({nm, ".present"}, log_q[k].size(), idx + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int lasts;
    int zeros;
    reset = 1'b1;
    st = '0;
    cm = '0;
    rdy = '0;
    repeat (3) tick();
    @(negedge clock);
    check("reset.valid", int'(v[0]), 0);
    check("reset.row", int'(r0), 0);
    check("reset.col", int'(c0), 0);
    check("reset.prod", int'(p0), 0);
    check("reset.last", int'(l[0]), 0);
    check("reset.busy", int'(b[0]), 0);
    check("reset.done", int'(dn[0]), 0);
    tick();
    reset = 1'b0;
    tick();

    // Default row-major scan with continuous ready.
    run_scan(0, 1'b0, 0, -1, -1, cyc);
    check("rm.count", log_q[0].size(), 25);
    check("rm.cycles", cyc, 27);
    check_x("rm.first", 0, 0, 0, 0, 0);
    check_x("rm.e5", 0, 5, 1, 0, 0);
    check_x("rm.e13", 0, 13, 2, 3, 6);
    check_x("rm.end", 0, 24, 4, 4, 16);
    lasts = 0;
    foreach (log_q[0][i]) lasts += int'(log_q[0][i].last);
    check("rm.last_count", lasts, 1);
    if (log_q[0].size() == 25) check("rm.last_on_end", int'(log_q[0][24].last), 1);

    // Column-major 3x4.
    run_scan(1, 1'b1, 0, -1, -1, cyc);
    check("cm.count", log_q[1].size(), 12);
    check("cm.cycles", cyc, 14);
    check_x("cm.e1", 1, 1, 1, 0, 0);
    check_x("cm.e3", 1, 3, 0, 1, 0);
    check_x("cm.end", 1, 11, 2, 3, 6);

    // Zero indices skipped.
    run_scan(2, 1'b0, 0, -1, -1, cyc);
    check("sz.count", log_q[2].size(), 16);
    check("sz.cycles", cyc, 18);
    check_x("sz.first", 2, 0, 1, 1, 1);
    check_x("sz.e4", 2, 4, 2, 1, 2);
    check_x("sz.end", 2, 15, 4, 4, 16);
    zeros = 0;
    foreach (log_q[2][i]) zeros += int'(log_q[2][i].r == 0 || log_q[2][i].c == 0);
    check("sz.no_zero_index", zeros, 0);

    // Single-row table with zero skipping has nothing to emit.
    run_scan(3, 1'b0, 0, -1, -1, cyc);
    check("empty.done_cycle", cyc, 2);
    check("empty.count", log_q[3].size(), 0);

    // Backpressure 1-of-3 plus an ignored start at entry 7.
    run_scan(0, 1'b0, 1, 7, -1, cyc);
    check("bp.count", log_q[0].size(), 25);
    check("bp.min_cycles", int'(cyc >= 75), 1);
    check_x("bp.e7", 0, 7, 1, 2, 2);
    check_x("bp.end", 0, 24, 4, 4, 16);

    // Reset at entry 10 aborts the scan; the next start begins afresh.
    run_scan(0, 1'b0, 0, -1, 10, cyc);
    @(negedge clock);
    check("rst.valid", int'(v[0]), 0);
    check("rst.busy", int'(b[0]), 0);
    check("rst.done", int'(dn[0]), 0);
    check("rst.count", log_q[0].size(), 10);
    run_scan(0, 1'b0, 0, -1, -1, cyc);
    check("rst.restart_count", log_q[0].size(), 25);
    check_x("rst.restart_first", 0, 0, 0, 0, 0);

    // Randomized scans: ready, stray starts and col_major wiggle under the model.
    for (int n = 0; n < 12; n++) begin
      automatic int k = $urandom_range(0, 2);
      automatic bit c = 1'($urandom_range(0, 1));
      automatic int expect_n = (k == 0) ? 25 : (k == 1) ? 12 : 16;
      run_scan(k, c, 2, -1, -1, cyc);
      check($sformatf("rand%0d.count", n), log_q[k].size(), expect_n);
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
